// File: rtl/vmul_ctrl_pkg.sv
// Shared types and lane geometry for the vector multiplier issue controller.
package vmul_ctrl_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PROD_W    = 64;
  localparam int unsigned CNT_W     = 4;

  localparam int unsigned LANES_8   = 4;
  localparam int unsigned LANE_W_8  = 8;
  localparam int unsigned LANES_16  = 2;
  localparam int unsigned LANE_W_16 = 16;
  localparam int unsigned LANES_32  = 1;
  localparam int unsigned LANE_W_32 = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    PREC_8    = 2'b00,
    PREC_16   = 2'b01,
    PREC_32   = 2'b10,
    PREC_RSVD = 2'b11
  } prec_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  // Every opcode except plain mul returns the upper half of each lane product.
  function automatic logic is_high(input opcode_e op);
    return op != OP_MUL;
  endfunction

endpackage

// File: rtl/vmul_issue_ctrl_if.sv
// Request/response handshake bundle between the vector issue stage and the multiplier controller.
interface vmul_issue_ctrl_if #(
  parameter int unsigned TAG_W = 4
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_opcode;
  logic [1:0]       req_precision;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_opcode, req_precision, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_precision, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
  );

endinterface

// File: rtl/vmul_result_pack.sv
// Selects the low or high half of each lane product and packs the lanes into one 32-bit word.
module vmul_result_pack
  import vmul_ctrl_pkg::*;
(
  input  logic [PROD_W-1:0] product,
  input  opcode_e           opcode,
  input  prec_e             precision,
  output logic [DATA_W-1:0] result
);

  logic hi;

  assign hi = is_high(opcode);

  // Lane i of width W sits at product[2*W*i +: 2*W]; the high half starts W bits above that.
  always_comb begin
    result = '0;
    case (precision)
      PREC_8: begin
        for (int i = 0; i < LANES_8; i++) begin
          result[LANE_W_8*i +: LANE_W_8] = hi ? product[2*LANE_W_8*i + LANE_W_8 +: LANE_W_8]
                                              : product[2*LANE_W_8*i +: LANE_W_8];
        end
      end
      PREC_16: begin
        for (int i = 0; i < LANES_16; i++) begin
          result[LANE_W_16*i +: LANE_W_16] = hi ? product[2*LANE_W_16*i + LANE_W_16 +: LANE_W_16]
                                                : product[2*LANE_W_16*i +: LANE_W_16];
        end
      end
      PREC_32: begin
        for (int i = 0; i < LANES_32; i++) begin
          result[LANE_W_32*i +: LANE_W_32] = hi ? product[2*LANE_W_32*i + LANE_W_32 +: LANE_W_32]
                                                : product[2*LANE_W_32*i +: LANE_W_32];
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vmul_issue_ctrl.sv
// Issue/sequencing controller: accepts one multiply at a time, drives the datapath,
// waits its fixed latency, then returns the packed lane results over a response handshake.
module vmul_issue_ctrl
  import vmul_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  vmul_issue_ctrl_if.slave  bus,
  output logic              dp_start,
  output logic [1:0]        dp_opcode,
  output logic [1:0]        dp_precision,
  output logic [DATA_W-1:0] dp_operand_a,
  output logic [DATA_W-1:0] dp_operand_b,
  input  logic [PROD_W-1:0] dp_product,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  opcode_e            opcode_q, opcode_d;
  prec_e              prec_q, prec_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic               start_q, start_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               ready;
  logic               accept;
  logic [DATA_W-1:0]  packed_result;

  // Ready is held low while in reset so nothing is accepted before the FSM is live.
  assign ready  = rst_n & (state_q == S_IDLE) & ~flush;
  assign accept = ready & bus.req_valid;

  vmul_result_pack u_pack (
    .product   (dp_product),
    .opcode    (opcode_q),
    .precision (prec_q),
    .result    (packed_result)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opcode_d     = opcode_q;
    prec_d       = prec_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rsp_tag_d = bus.req_tag;
          if (prec_e'(bus.req_precision) == PREC_RSVD) begin
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
            state_d      = S_RESP;
          end else begin
            opcode_d = opcode_e'(bus.req_opcode);
            prec_d   = prec_e'(bus.req_precision);
            a_d      = bus.req_a;
            b_d      = bus.req_b;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MUL_LAT - 1);
        state_d = (MUL_LAT == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        rsp_result_d = packed_result;
        rsp_err_d    = 1'b0;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any handshake in the same cycle.
    if (flush) begin
      state_d = S_IDLE;
    end

    start_d     = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      opcode_q     <= OP_MUL;
      prec_q       <= PREC_8;
      a_q          <= '0;
      b_q          <= '0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opcode_q     <= opcode_d;
      prec_q       <= prec_d;
      a_q          <= a_d;
      b_q          <= b_d;
      start_q      <= start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
  assign dp_start       = start_q;
  assign dp_opcode      = opcode_q;
  assign dp_precision   = prec_q;
  assign dp_operand_a   = a_q;
  assign dp_operand_b   = b_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
// Self-checking bench for vmul_issue_ctrl: arithmetic lane-product model as datapath and as reference.
module tb_vmul_issue_ctrl;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned TAG_W   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        dp_start;
  logic [1:0]  dp_opcode;
  logic [1:0]  dp_precision;
  logic [31:0] dp_operand_a;
  logic [31:0] dp_operand_b;
  logic [63:0] dp_product = '0;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;

  vmul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  vmul_issue_ctrl #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus.slave),
    .dp_start     (dp_start),
    .dp_opcode    (dp_opcode),
    .dp_precision (dp_precision),
    .dp_operand_a (dp_operand_a),
    .dp_operand_b (dp_operand_b),
    .dp_product   (dp_product),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Full signed/unsigned product of one lane of width w, as a 64-bit two's-complement value.
  function automatic logic [63:0] lane_prod(input logic [1:0] op, input int w,
                                            input logic [31:0] a, input logic [31:0] b);
    longint av, bv, m;
    m  = (longint'(1) << w) - 1;
    av = longint'({32'd0, a}) & m;
    bv = longint'({32'd0, b}) & m;
    if ((op == 2'b01 || op == 2'b10) && av[w-1]) av = av - (longint'(1) << w);
    if (op == 2'b01 && bv[w-1]) bv = bv - (longint'(1) << w);
    return 64'(av * bv);
  endfunction

  function automatic logic [63:0] model_product(input logic [1:0] op, input logic [1:0] prec,
                                                input logic [31:0] a, input logic [31:0] b);
    int w;
    logic [63:0] p, lp, m2;
    p = '0;
    if (prec == 2'b11) return p;
    w  = 8 << int'(prec);
    m2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    for (int i = 0; i < 32 / w; i++) begin
      lp = lane_prod(op, w, a >> (w * i), b >> (w * i));
      p  = p | ((lp & m2) << (2 * w * i));
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [1:0] prec,
                                             input logic [31:0] a, input logic [31:0] b);
    int w;
    logic [31:0] r;
    logic [63:0] lp, h, mw;
    r = '0;
    if (prec == 2'b11) return r;
    w  = 8 << int'(prec);
    mw = (64'd1 << w) - 64'd1;
    for (int i = 0; i < 32 / w; i++) begin
      lp = lane_prod(op, w, a >> (w * i), b >> (w * i));
      h  = (op == 2'b00) ? lp : (lp >> w);
      r  = r | 32'((h & mw) << (w * i));
    end
    return r;
  endfunction

  // Datapath stand-in: product is valid only in the cycle MUL_LAT after dp_start, noise otherwise.
  int          dp_age = 0;
  bit          dp_active = 1'b0;
  logic [63:0] dp_p = '0;
  always @(posedge clk) begin
    #1;
    if (dp_age > 0) dp_age--;
    if (dp_active && dp_age == 0) begin
      dp_product = dp_p;
      dp_active  = 1'b0;
    end else begin
      dp_product = {$urandom, $urandom};
    end
    if (dp_start) begin
      n_start++;
      dp_p      = model_product(dp_opcode, dp_precision, dp_operand_a, dp_operand_b);
      dp_age    = int'(MUL_LAT);
      dp_active = 1'b1;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] prec, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag,
                       output int t0, output bit ok);
    ok = 1'b0;
    t0 = 0;
    bus.req_valid     = 1'b1;
    bus.req_opcode    = op;
    bus.req_precision = prec;
    bus.req_a         = a;
    bus.req_b         = b;
    bus.req_tag       = tag;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        t0 = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.req_valid     = 1'b0;
    bus.req_opcode    = 2'($urandom);
    bus.req_precision = 2'($urandom);
    bus.req_a         = $urandom;
    bus.req_b         = $urandom;
    bus.req_tag       = TAG_W'($urandom);
  endtask

  task automatic wait_rsp(output int t, output logic [31:0] res, output logic err,
                          output logic [TAG_W-1:0] tag, output bit ok);
    ok = 1'b0; t = 0; res = '0; err = 1'b0; tag = '0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        t   = cyc;
        res = bus.rsp_result;
        err = bus.rsp_err;
        tag = bus.rsp_tag;
        ok  = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.req_ready, bus.rsp_valid, dp_start, busy, bus.rsp_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/vld/start/busy/err=%b want 00000",
               {bus.req_ready, bus.rsp_valid, dp_start, busy, bus.rsp_err});
    end
    n_vec++;
    if ({bus.rsp_result, dp_operand_a, dp_operand_b} !== 96'd0) begin
      n_err++;
      $display("FAIL reset_data: got result=%h a=%h b=%h want zeros",
               bus.rsp_result, dp_operand_a, dp_operand_b);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got ready=%b busy=%b want 1 0", bus.req_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_check(input string name, input logic [1:0] op, input logic [1:0] prec,
                           input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                           input logic [31:0] want);
    int t0, t1, s0, want_lat, want_starts;
    bit ok0, ok1;
    logic [31:0] res;
    logic err;
    logic [TAG_W-1:0] rtag;
    s0 = n_start;
    want_lat    = (prec == 2'b11) ? 1 : int'(MUL_LAT) + 2;
    want_starts = (prec == 2'b11) ? 0 : 1;
    issue(op, prec, a, b, tag, t0, ok0);
    wait_rsp(t1, res, err, rtag, ok1);
    n_vec++;
    if (!ok0 || !ok1) begin
      n_err++;
      $display("FAIL %s_timeout: accepted=%0d responded=%0d want 1 1", name, ok0, ok1);
    end
    n_vec++;
    if (res !== want || err !== (prec == 2'b11) || rtag !== tag) begin
      n_err++;
      $display("FAIL %s_data: got result=%h err=%b tag=%h want %h %b %h",
               name, res, err, rtag, want, prec == 2'b11, tag);
    end
    n_vec++;
    if (t1 - t0 !== want_lat || n_start - s0 !== want_starts) begin
      n_err++;
      $display("FAIL %s_timing: got latency=%0d starts=%0d want %0d %0d",
               name, t1 - t0, n_start - s0, want_lat, want_starts);
    end
  endtask

  task automatic test_directed();
    bus.rsp_ready = 1'b1;
    run_check("mulhu32", 2'b11, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 32'hFFFF_FFFE);
    run_check("mul8",    2'b00, 2'b00, 32'h0203_0405, 32'h1010_1010, 4'hA, 32'h2030_4050);
    run_check("mulh16",  2'b01, 2'b01, 32'hFFFF_0002, 32'h0003_8000, 4'h6, 32'hFFFF_FFFF);
  endtask

  task automatic test_reserved();
    bus.rsp_ready = 1'b1;
    run_check("reserved", 2'($urandom), 2'b11, $urandom, $urandom, 4'h5, 32'h0);
  endtask

  task automatic test_backpressure();
    int t0, t1, hs, t2;
    bit ok0, ok1;
    logic [31:0] res, want;
    logic err;
    logic [TAG_W-1:0] rtag;
    bit stable;
    bus.rsp_ready = 1'b0;
    want = ref_result(2'b10, 2'b00, 32'h80FF_7F01, 32'hFF80_0202);
    issue(2'b10, 2'b00, 32'h80FF_7F01, 32'hFF80_0202, 4'h9, t0, ok0);
    wait_rsp(t1, res, err, rtag, ok1);
    n_vec++;
    if (!ok1 || res !== want || err !== 1'b0 || rtag !== 4'h9) begin
      n_err++;
      $display("FAIL bp_first: got ok=%0d result=%h err=%b tag=%h want 1 %h 0 9",
               ok1, res, err, rtag, want);
    end
    stable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== res || bus.rsp_tag !== rtag ||
          bus.rsp_err !== err || bus.req_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_vec++;
    if (!stable) begin
      n_err++;
      $display("FAIL bp_hold: got outputs changing under back-pressure want held");
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    hs = cyc;
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== res) begin
      n_err++;
      $display("FAIL bp_accept: got valid=%b result=%h want 1 %h", bus.rsp_valid, bus.rsp_result, res);
    end
    @(posedge clk); #1;
    issue(2'b00, 2'b10, 32'd7, 32'd9, 4'h1, t2, ok0);
    n_vec++;
    if (!ok0 || t2 !== hs + 1) begin
      n_err++;
      $display("FAIL bp_next_accept: got accept cycle=%0d want %0d", t2, hs + 1);
    end
    wait_rsp(t1, res, err, rtag, ok1);
    n_vec++;
    if (!ok1 || res !== 32'd63) begin
      n_err++;
      $display("FAIL bp_next_result: got ok=%0d result=%h want 1 0000003f", ok1, res);
    end
  endtask

  task automatic test_flush_and_reset();
    int t0, t1;
    bit ok0, ok1, seen;
    logic [31:0] res;
    logic err;
    logic [TAG_W-1:0] rtag;
    bus.rsp_ready = 1'b1;
    issue(2'b01, 2'b10, $urandom, $urandom, 4'h2, t0, ok0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_pre: got busy=%b ready=%b want 1 0", busy, bus.req_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, bus.rsp_valid, dp_start, bus.req_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL flush_idle: got busy/vld/start/rdy=%b want 0001",
               {busy, bus.rsp_valid, dp_start, bus.req_ready});
    end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL flush_no_rsp: got response for dropped op want none");
    end
    bus.rsp_ready = 1'b0;
    issue(2'b11, 2'b01, $urandom, $urandom, 4'hC, t0, ok0);
    wait_rsp(t1, res, err, rtag, ok1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.rsp_valid, busy, bus.req_ready} !== 3'b000 || !ok1) begin
      n_err++;
      $display("FAIL reset_mid_resp: got vld/busy/rdy=%b ok=%0d want 000 1",
               {bus.rsp_valid, busy, bus.req_ready}, ok1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    run_check("after_reset", 2'b00, 2'b01, 32'h1234_ABCD, 32'h0011_0003,
              4'h7, ref_result(2'b00, 2'b01, 32'h1234_ABCD, 32'h0011_0003));
  endtask

  task automatic test_random();
    int t0, t1, want_lat, s0;
    bit ok0, ok1;
    logic [1:0] op, prec;
    logic [31:0] a, b, res, want;
    logic err;
    logic [TAG_W-1:0] tag, rtag;
    for (int n = 0; n < 40; n++) begin
      op   = 2'($urandom);
      prec = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      tag  = TAG_W'($urandom);
      want = ref_result(op, prec, a, b);
      want_lat = (prec == 2'b11) ? 1 : int'(MUL_LAT) + 2;
      s0 = n_start;
      bus.rsp_ready = 1'($urandom);
      issue(op, prec, a, b, tag, t0, ok0);
      wait_rsp(t1, res, err, rtag, ok1);
      n_vec++;
      if (!ok0 || !ok1 || res !== want || err !== (prec == 2'b11) || rtag !== tag) begin
        n_err++;
        $display("FAIL rand%0d_data: op=%b prec=%b a=%h b=%h got result=%h err=%b tag=%h want %h %b %h",
                 n, op, prec, a, b, res, err, rtag, want, prec == 2'b11, tag);
      end
      n_vec++;
      if (t1 - t0 !== want_lat || (n_start - s0) !== ((prec == 2'b11) ? 0 : 1)) begin
        n_err++;
        $display("FAIL rand%0d_timing: got latency=%0d starts=%0d want %0d", n, t1 - t0,
                 n_start - s0, want_lat);
      end
      if (!bus.rsp_ready) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== want) begin
          n_err++;
          $display("FAIL rand%0d_hold: got valid=%b result=%h want 1 %h", n, bus.rsp_valid,
                   bus.rsp_result, want);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_opcode    = 2'b00;
    bus.req_precision = 2'b00;
    bus.req_a         = '0;
    bus.req_b         = '0;
    bus.req_tag       = '0;
    bus.rsp_ready     = 1'b1;
    test_reset();
    test_directed();
    test_reserved();
    test_backpressure();
    test_flush_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
